// File: rtl/el2_clmul_pkg.sv
// Shared definitions for the sequential carry-less multiply unit:
// op encodings, FSM state type and the iteration count as a function of XLEN.
package el2_clmul_pkg;

  localparam logic [1:0] CLMUL_OP_LO  = 2'b00;
  localparam logic [1:0] CLMUL_OP_HI  = 2'b01;
  localparam logic [1:0] CLMUL_OP_REV = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } clmul_state_e;

  // One iteration per (rs1 byte, rs2 byte) pair.
  function automatic int clmul_iters(input int xlen);
    return (xlen / 8) * (xlen / 8);
  endfunction

endpackage

// File: rtl/el2_exu_clmul_seq_clmul8.sv
// 8x8 carry-less multiplier: purely combinational 16-bit partial product.
module clmul8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // NOTE: p gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    p = '0;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ ({8'h00, a} << k);
    end
  end

endmodule

// File: rtl/el2_exu_clmul_seq.sv
// Multi-cycle carry-less multiply (clmul / clmulh / clmulr) over byte pairs via one clmul8.
// Optional macro CLMUL_ZERO_SKIP_EN: a zero operand bypasses the iteration and finishes in one cycle.
module el2_exu_clmul_seq
  import el2_clmul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            valid_in,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            ready_out,
  output logic            valid_out,
  output logic [XLEN-1:0] result
);

  localparam int NB    = XLEN / 8;
  localparam int ITERS = clmul_iters(XLEN);
  localparam int NBW   = $clog2(NB);
  localparam int CW    = $clog2(ITERS);

  clmul_state_e       state_q, state_d;
  logic [XLEN-1:0]    a_q, b_q;
  logic [1:0]         op_q;
  logic [2*XLEN-1:0]  acc_q;
  logic [CW-1:0]      cnt_q;
  logic [XLEN-1:0]    result_q;

  logic               accept;
  logic               last_iter;
  logic               zero_ops;
  logic [NBW-1:0]     idx_i, idx_j;
  logic [7:0]         byte_a, byte_b;
  logic [15:0]        partial;
  logic [NBW+3:0]     shamt;
  logic [2*XLEN-1:0]  partial_sh;
  logic [XLEN-1:0]    result_sel;

  assign ready_out = (state_q == IDLE);
  assign accept    = valid_in & ready_out & ~flush;
  assign last_iter = (cnt_q == CW'(ITERS - 1));

`ifdef CLMUL_ZERO_SKIP_EN
  assign zero_ops = (rs1 == '0) | (rs2 == '0);
`else
  assign zero_ops = 1'b0;
`endif

  // cnt walks rs1 bytes fastest: i = cnt mod NB, j = cnt / NB.
  assign idx_i  = cnt_q[NBW-1:0];
  assign idx_j  = cnt_q[CW-1:NBW];
  assign byte_a = a_q[{idx_i, 3'b000} +: 8];
  assign byte_b = b_q[{idx_j, 3'b000} +: 8];

  clmul8 u_clmul8 (
    .a (byte_a),
    .b (byte_b),
    .p (partial)
  );

  assign shamt      = {({1'b0, idx_i} + {1'b0, idx_j}), 3'b000};
  assign partial_sh = {{(2*XLEN-16){1'b0}}, partial} << shamt;

  always_comb begin
    case (op_q)
      CLMUL_OP_HI:  result_sel = acc_q[2*XLEN-1:XLEN];
      CLMUL_OP_REV: result_sel = acc_q[2*XLEN-2:XLEN-1];
      default:      result_sel = acc_q[XLEN-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = zero_ops ? DONE : BUSY;
      BUSY:    if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // The result is visible in the DONE cycle itself and held in result_q afterwards.
  assign valid_out = (state_q == DONE) & ~flush;
  assign result    = valid_out ? result_sel : result_q;

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= CLMUL_OP_LO;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: if (accept) begin
            a_q   <= rs1;
            b_q   <= rs2;
            op_q  <= op;
            acc_q <= '0;
            cnt_q <= '0;
          end
          BUSY: begin
            acc_q <= acc_q ^ partial_sh;
            cnt_q <= cnt_q + CW'(1);
          end
          DONE:    result_q <= result_sel;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/el2_exu_clmul_seq.md
Name: el2_exu_clmul_seq

Overview:
- Multi-cycle carry-less multiply unit for the EXU. It is the consumer of the 8x8 carry-less multiplier clmul8.
- Iterates over byte pairs of rs1/rs2 through one clmul8 instance and XOR-accumulates the shifted 16-bit partials into a 2*XLEN product.
- Returns the clmul (low), clmulh (high) or clmulr (reversed) word.
- Sits beside the divider: single-issue, non-pipelined, flushable.

Parameters:
- XLEN, 32, operand width; legal values 32 or 64. NB = XLEN/8 bytes per operand; iterations = NB*NB (16 or 64).

Ports:
- clk  in  1  core clock
- rst_l  in  1  asynchronous active-low reset
- valid_in  in  1  request strobe
- op  in  2  00=clmul, 01=clmulh, 10=clmulr, 11=reserved (treated as clmul)
- rs1  in  XLEN  operand A
- rs2  in  XLEN  operand B
- flush  in  1  kill any in-flight op
- ready_out  out  1  high only in IDLE; request accepted when valid_in & ready_out & !flush
- valid_out  out  1  one-cycle result strobe; no backpressure
- result  out  XLEN  result word; held until next valid_out

Behaviour:
- Reset: state=IDLE, ready_out=1, valid_out=0, result=0, acc=0, cnt=0. Reset is asynchronous and active-low on rst_l, with a single clock clk; reset mid-operation aborts immediately with no valid_out.
- State IDLE, on accept:
  - Latch rs1, rs2 and op.
  - Clear acc (2*XLEN bits) and cnt.
  - Go to BUSY.
- State BUSY, each cycle:
  - i = cnt mod NB, j = cnt / NB.
  - p = clmul8(rs1 byte i, rs2 byte j).
  - acc ^= zero-extend(p) << 8*(i+j).
  - cnt++.
  - When cnt == NB*NB-1, the final partial is accumulated and the FSM goes to DONE.
- State DONE:
  - valid_out=1 for exactly one cycle.
  - result = acc[XLEN-1:0] (clmul), acc[2XLEN-1:XLEN] (clmulh), or acc[2XLEN-2:XLEN-1] (clmulr).
  - Next state IDLE.
- Latency: accept in cycle 0, valid_out in cycle NB*NB+1 (17 for XLEN=32). Next accept is possible in cycle NB*NB+2.
- valid_in while ready_out=0 is ignored; the caller must hold or re-issue it.
- Flush:
  - Takes priority in every state; next state is IDLE, cnt cleared, valid_out suppressed, result unchanged.
  - Flush in the same cycle as valid_in means the request is not accepted.
  - Flush in DONE suppresses valid_out that cycle.
- Partial shift never exceeds 2*XLEN-1: the max shift 8*(2NB-2) plus 15 bits equals 2XLEN-2.

Optional Feature:
- Macro CLMUL_ZERO_SKIP_EN.
- Defined: on accept, if rs1==0 or rs2==0, go straight to DONE with acc=0. valid_out then arrives in cycle 1 with result 0.
- Undefined: all operands take the full NB*NB+1 latency; there is no operand-detect logic.

Decomposition:
- Shared package el2_clmul_pkg holds:
  - op encoding constants (CLMUL_OP_LO/HI/REV)
  - state enum (IDLE, BUSY, DONE)
  - the iteration-count function of XLEN
- One sub-module: the existing clmul8, instantiated once. Byte-select muxes, the shifter and the accumulator stay in this block.

Test Plan:
- rs1=0x00000003, rs2=0x00000003, op=clmul -> valid_out in cycle 17, result=0x00000005.
- rs1=rs2=0x80000000 -> clmulh result=0x40000000; clmulr result=0x80000000; clmul result=0x00000000.
- rs1=rs2=0xFFFFFFFF -> clmul=0x55555555, clmulh=0x55555555; clmulr=0xAAAAAAAA (acc[62:31]: bit 31 from acc[62]=1).
- Start an op, assert flush in cycle 8:
  - No valid_out; ready_out=1 in cycle 9.
  - A new op rs1=0x3, rs2=0x3 issued then yields 0x5; no residue from the killed op.
- Hold valid_in with different operands during BUSY -> ignored; the original result is returned. Deassert rst_l in cycle 5 -> all outputs return to reset values asynchronously, with no valid_out.
- rs2=0x00000000, rs1=0x12345678:
  - With CLMUL_ZERO_SKIP_EN: valid_out in cycle 1, result 0.
  - Without it: valid_out in cycle 17, result 0.
  - Repeat with XLEN=64: valid_out in cycle 65 (skip disabled).
